music_box_mode_scheduler: RTL and testbench
===========================================

Name: music_box_mode_scheduler

Overview:
Top-level sequencer for the music box user interface. It accepts debounced button requests, grants exactly one play/record mode at a time, and drives the 5-bit currentState bus consumed by every MusicBoxState_* module. It returns to DoNothing when the active mode reports completion, on a cancel press, or on watchdog timeout. It runs on clock_50Mhz and uses clock_1Khz only as a sampled timebase.

Parameters:
SYNC_STAGES, 2, flops per synchronizer on every asynchronous input (minimum 2).
TIMEOUT_MS, 30000, 1 kHz ticks allowed in any active mode before a forced return to DoNothing.
HOLDOFF_MS, 20, 1 kHz ticks spent in DoNothing after any exit before a new request is accepted.

Ports:
clock_50Mhz  in  1  system clock; all state is registered on its rising edge.
reset_n  in  1  asynchronous active-low reset.
clock_1Khz  in  1  slow timebase; sampled, never used as a clock.
buttonRequest  in  4  level requests, active-high: [0] Song1, [1] Song2, [2] Record, [3] Playback.
cancelRequest  in  1  level, active-high; a rising edge aborts the active mode.
stateCompleteVec  in  5  per-state completion flags; bit index equals state code; asynchronous to clock_50Mhz.
currentState  out  5  granted mode: 0 DoNothing, 1 PlaySong1, 2 PlaySong2, 3 RecordSong, 4 PlayRecording.
recordingValid  out  1  high once a RecordSong has finished through its completion flag.
timeoutFlag  out  1  one-cycle pulse on a watchdog abort.
debugString  out  32  {currentState[4:0], recordingValid, holdoffActive, 9'b0, tickCounter[15:0]}.

Behaviour:
- Reset: currentState=0, recordingValid=0, timeoutFlag=0, tickCounter=0, holdoffActive=0, all synchronizers and edge registers cleared. Reset mid-mode aborts immediately.
- Synchronization: buttonRequest, cancelRequest, stateCompleteVec and clock_1Khz each pass through SYNC_STAGES flops. A rising edge is sync output high while the previous registered value is low. tick is a one-cycle pulse on each clock_1Khz rising edge.
- Latency: an input rising edge changes currentState on the (SYNC_STAGES+1)th clock_50Mhz edge, which is 3 with the default.
- DoNothing (0):
  - Grant only while holdoffActive=0.
  - Rising edges on buttonRequest grant the lowest set index. Simultaneous edges: the lowest index wins and the others are dropped, not queued.
  - Bit[3] (Playback) is ignored while recordingValid=0.
  - Level-high requests without a new edge never grant.
- Active states (1..4):
  - tickCounter clears on entry and increments on each tick.
  - Exit to 0 when the first of these occurs, in priority order: (a) cancel edge, (b) synchronized stateCompleteVec[currentState]=1, (c) tickCounter==TIMEOUT_MS-1 coincident with tick, which also sets timeoutFlag for one cycle.
  - Completion bits of other states are ignored. Button edges are ignored.
- Exit from RecordSong via (b) sets recordingValid=1, which stays set until reset. Exit via (a) or (c) leaves recordingValid unchanged.
- Every exit to 0 sets holdoffActive=1 and clears tickCounter. holdoffActive clears when HOLDOFF_MS ticks have elapsed. This guarantees the mode module has seen currentState!=its code on its own 1 kHz edge and dropped stateComplete.
- Entering DoNothing is never blocked. Completion and cancel in the same cycle count as cancel and do not set recordingValid.
- tickCounter is 16 bits and saturates at 16'hFFFF. It is never compared beyond TIMEOUT_MS, so there is no wrap-around hazard.
- Illegal currentState (5..31) is unreachable. The default transition goes to 0.

Decomposition:
- Package music_box_pkg: state codes as a 5-bit enum (DO_NOTHING..PLAY_RECORDING), NUM_STATES=5, button index constants, DEBUG_WIDTH=32.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES): outputs sync_level and rise_pulse. It is instantiated for the 4 buttons, cancel, 5 completion bits and clock_1Khz.

Test Plan:
- Reset, then raise buttonRequest[0] at cycle 10 -> currentState=1 at cycle 13; hold level for 100 cycles -> no re-grant after return.
- In state 1, raise stateCompleteVec[1] -> currentState=0 within 3 cycles; pulse buttonRequest[1] during the 20 ms holdoff -> ignored; pulse it after the holdoff -> currentState=2.
- Raise buttonRequest[1] and [2] on the same cycle -> currentState=2. Pulse buttonRequest[3] with recordingValid=0 -> currentState stays 0.
- Record: grant 3, assert stateCompleteVec[3] -> recordingValid=1; after holdoff, pulse buttonRequest[3] -> currentState=4.
- With TIMEOUT_MS=10, grant 1 and give no completion -> after the 10th tick currentState=0 and timeoutFlag high for exactly 1 cycle.
- In state 3, assert cancel and stateCompleteVec[3] on the same cycle -> currentState=0, recordingValid stays 0. Pulse reset_n low mid-mode -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/music_box_pkg.sv
// -----------------------------------------------------------------------------
// music_box_pkg
// Shared definitions for the music box mode scheduler: the 5-bit state codes
// driven on currentState, button bit positions within buttonRequest, and bus
// widths used by the scheduler interface.
// -----------------------------------------------------------------------------
package music_box_pkg;

   localparam int NUM_STATES  = 5;
   localparam int NUM_BUTTONS = 4;
   localparam int DEBUG_WIDTH = 32;

   // Codes are fixed: every MusicBoxState_* module decodes these values.
   typedef enum logic [4:0] {
      DO_NOTHING     = 5'd0,
      PLAY_SONG1     = 5'd1,
      PLAY_SONG2     = 5'd2,
      RECORD_SONG    = 5'd3,
      PLAY_RECORDING = 5'd4
   } state_e;

   localparam int BTN_SONG1    = 0;
   localparam int BTN_SONG2    = 1;
   localparam int BTN_RECORD   = 2;
   localparam int BTN_PLAYBACK = 3;

endpackage

// File: rtl/music_box_mode_scheduler_if.sv
// -----------------------------------------------------------------------------
// music_box_mode_scheduler_if
// Groups the scheduler's request/status signals.
//   master : user-interface side, drives requests and completion flags
//   slave  : the scheduler, drives the granted mode and status outputs
// Signals:
//   buttonRequest    level requests [0] Song1 [1] Song2 [2] Record [3] Playback
//   cancelRequest    level, rising edge aborts the active mode
//   stateCompleteVec per-state completion flags, bit index = state code
//   currentState     granted mode code
//   recordingValid   a recording has completed since reset
//   timeoutFlag      one-cycle pulse on a watchdog abort
//   debugString      packed status snapshot
// -----------------------------------------------------------------------------
interface music_box_mode_scheduler_if;
   import music_box_pkg::*;

   logic [NUM_BUTTONS-1:0] buttonRequest;
   logic                   cancelRequest;
   logic [NUM_STATES-1:0]  stateCompleteVec;
   logic [4:0]             currentState;
   logic                   recordingValid;
   logic                   timeoutFlag;
   logic [DEBUG_WIDTH-1:0] debugString;

   modport master (
      output buttonRequest, cancelRequest, stateCompleteVec,
      input  currentState, recordingValid, timeoutFlag, debugString
   );

   modport slave (
      input  buttonRequest, cancelRequest, stateCompleteVec,
      output currentState, recordingValid, timeoutFlag, debugString
   );

endinterface

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings a WIDTH-bit asynchronous vector into the clock_50Mhz domain through a
// SYNC_STAGES-deep flop chain and flags rising edges of the synchronized value.
// Ports:
//   clock_50Mhz  system clock
//   reset_n      asynchronous active-low reset, clears the whole chain
//   async_in     asynchronous input vector
//   sync_level   synchronized level (last chain stage)
//   rise_pulse   one-cycle pulse: sync_level high while previous value low
// -----------------------------------------------------------------------------
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 1
) (
   input  logic             clock_50Mhz,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_level,
   output logic [WIDTH-1:0] rise_pulse
);

   // Fewer than two stages is not a safe synchronizer, so clamp upward.
   localparam int STAGES_EFF = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [WIDTH-1:0] sync_q [STAGES_EFF];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES_EFF; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < STAGES_EFF; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[STAGES_EFF-1];
      end
   end

   assign sync_level = sync_q[STAGES_EFF-1];
   // Combinational so the FSM can act on the edge one flop later.
   assign rise_pulse = sync_level & ~prev_q;

endmodule

// File: rtl/music_box_mode_scheduler.sv
// -----------------------------------------------------------------------------
// music_box_mode_scheduler
// Grants one music box mode at a time from debounced button edges and returns
// to DoNothing on completion, cancel or watchdog timeout. After every exit a
// holdoff of HOLDOFF_MS slow ticks blocks new grants so the mode module can
// observe the state change on its own 1 kHz edge and drop its completion flag.
// Ports:
//   clock_50Mhz  system clock
//   reset_n      asynchronous active-low reset
//   clock_1Khz   slow timebase, sampled only
//   bus          slave side of music_box_mode_scheduler_if
// -----------------------------------------------------------------------------
module music_box_mode_scheduler
   import music_box_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_MS  = 30000,
   parameter int HOLDOFF_MS  = 20
) (
   input  logic                         clock_50Mhz,
   input  logic                         reset_n,
   input  logic                         clock_1Khz,
   music_box_mode_scheduler_if.slave    bus
);

   logic [NUM_BUTTONS-1:0] btn_level, btn_rise;
   logic                   cancel_level, cancel_rise;
   logic [NUM_STATES-1:0]  cmp_level, cmp_rise;
   logic                   tick_level, tick;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(NUM_BUTTONS)) u_sync_btn (
      .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .async_in(bus.buttonRequest),
      .sync_level(btn_level), .rise_pulse(btn_rise));

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_cancel (
      .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .async_in(bus.cancelRequest),
      .sync_level(cancel_level), .rise_pulse(cancel_rise));

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(NUM_STATES)) u_sync_cmp (
      .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .async_in(bus.stateCompleteVec),
      .sync_level(cmp_level), .rise_pulse(cmp_rise));

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_tick (
      .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .async_in(clock_1Khz),
      .sync_level(tick_level), .rise_pulse(tick));

   // Only rising edges of requests and the level of completion matter here.
   logic unused_ok;
   assign unused_ok = ^{btn_level, cancel_level, cmp_rise, tick_level, cmp_level[0]};

   state_e      state_q;
   logic        rec_valid_q;
   logic        holdoff_q;
   logic        timeout_q;
   logic [15:0] tick_cnt_q;
   logic        cur_complete;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Completion flag of the granted mode only; other modes' flags are ignored.
   always_comb begin
      cur_complete = 1'b0;
      case (state_q)
         PLAY_SONG1:     cur_complete = cmp_level[1];
         PLAY_SONG2:     cur_complete = cmp_level[2];
         RECORD_SONG:    cur_complete = cmp_level[3];
         PLAY_RECORDING: cur_complete = cmp_level[4];
         default:        cur_complete = 1'b0;
      endcase
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= DO_NOTHING;
         rec_valid_q <= 1'b0;
         holdoff_q   <= 1'b0;
         timeout_q   <= 1'b0;
         tick_cnt_q  <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            DO_NOTHING: begin
               if (holdoff_q) begin
                  // Edges arriving during holdoff are dropped, not queued.
                  if (tick) begin
                     if (tick_cnt_q == 16'(HOLDOFF_MS - 1)) begin
                        holdoff_q  <= 1'b0;
                        tick_cnt_q <= '0;
                     end else begin
                        tick_cnt_q <= sat_inc16(tick_cnt_q);
                     end
                  end
               end else if (btn_rise[BTN_SONG1]) begin
                  state_q    <= PLAY_SONG1;
                  tick_cnt_q <= '0;
               end else if (btn_rise[BTN_SONG2]) begin
                  state_q    <= PLAY_SONG2;
                  tick_cnt_q <= '0;
               end else if (btn_rise[BTN_RECORD]) begin
                  state_q    <= RECORD_SONG;
                  tick_cnt_q <= '0;
               end else if (btn_rise[BTN_PLAYBACK] && rec_valid_q) begin
                  state_q    <= PLAY_RECORDING;
                  tick_cnt_q <= '0;
               end
            end
            PLAY_SONG1, PLAY_SONG2, RECORD_SONG, PLAY_RECORDING: begin
               if (cancel_rise) begin
                  state_q    <= DO_NOTHING;
                  holdoff_q  <= 1'b1;
                  tick_cnt_q <= '0;
               end else if (cur_complete) begin
                  state_q    <= DO_NOTHING;
                  holdoff_q  <= 1'b1;
                  tick_cnt_q <= '0;
                  if (state_q == RECORD_SONG) rec_valid_q <= 1'b1;
               end else if (tick && (tick_cnt_q == 16'(TIMEOUT_MS - 1))) begin
                  state_q    <= DO_NOTHING;
                  holdoff_q  <= 1'b1;
                  tick_cnt_q <= '0;
                  timeout_q  <= 1'b1;
               end else if (tick) begin
                  tick_cnt_q <= sat_inc16(tick_cnt_q);
               end
            end
            default: begin
               state_q    <= DO_NOTHING;
               holdoff_q  <= 1'b1;
               tick_cnt_q <= '0;
            end
         endcase
      end
   end

   assign bus.currentState   = state_q;
   assign bus.recordingValid = rec_valid_q;
   assign bus.timeoutFlag    = timeout_q;
   assign bus.debugString    = {state_q, rec_valid_q, holdoff_q, 9'b0, tick_cnt_q};

endmodule

// File: tb/tb_music_box_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_music_box_mode_scheduler
// Scoreboard bench: each expected currentState transition (with the expected
// recordingValid and timeoutFlag at that moment) is queued when stimulus is
// driven, and popped and compared when the DUT changes state. Directed checks
// cover reset values, grant latency and ignored requests.
// clock_1Khz is sped up (one period = 8 system clocks) to keep runs short.
// -----------------------------------------------------------------------------
module tb_music_box_mode_scheduler;
   import music_box_pkg::*;

   localparam int TO_MS = 10;
   localparam int HO_MS = 20;

   logic clk = 1'b0;
   logic clk1k = 1'b0;
   logic reset_n = 1'b1;

   always #10 clk = ~clk;
   always #80 clk1k = ~clk1k;

   music_box_mode_scheduler_if bus ();

   music_box_mode_scheduler #(
      .SYNC_STAGES(2), .TIMEOUT_MS(TO_MS), .HOLDOFF_MS(HO_MS)
   ) dut (
      .clock_50Mhz(clk),
      .reset_n    (reset_n),
      .clock_1Khz (clk1k),
      .bus        (bus)
   );

   typedef struct packed {
      logic [4:0] st;
      logic       rv;
      logic       to;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   to_cycles = 0;
   logic [4:0] last_st = 5'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] st, input logic rv, input logic to);
      exp_t e;
      e.st = st; e.rv = rv; e.to = to;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: every state change must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.timeoutFlag === 1'b1) to_cycles++;
      if (bus.currentState !== last_st) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_change", {27'd0, bus.currentState}, {27'd0, last_st});
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_state", {27'd0, bus.currentState}, {27'd0, e.st});
            chk("sb_recvalid", {31'd0, bus.recordingValid}, {31'd0, e.rv});
            chk("sb_timeout", {31'd0, bus.timeoutFlag}, {31'd0, e.to});
         end
         last_st = bus.currentState;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [4:0] s, input int limit, input string tag);
      int n = 0;
      while (bus.currentState !== s && n < limit) begin
         step(1);
         n++;
      end
      chk(tag, {27'd0, bus.currentState}, {27'd0, s});
   endtask

   task automatic wait_holdoff(input string tag);
      int n = 0;
      while (bus.debugString[25] !== 1'b0 && n < 400) begin
         step(1);
         n++;
      end
      chk(tag, {31'd0, bus.debugString[25]}, 32'd0);
      step(2);
   endtask

   task automatic pulse_btn(input logic [3:0] b);
      bus.buttonRequest = b;
      step(3);
      bus.buttonRequest = 4'd0;
   endtask

   initial begin
      int t0, elapsed;
      bus.buttonRequest    = 4'd0;
      bus.cancelRequest    = 1'b0;
      bus.stateCompleteVec = 5'd0;
      #1 reset_n = 1'b0;
      step(3);
      chk("rst_state", {27'd0, bus.currentState}, 32'd0);
      chk("rst_recvalid", {31'd0, bus.recordingValid}, 32'd0);
      chk("rst_timeout", {31'd0, bus.timeoutFlag}, 32'd0);
      chk("rst_debug", bus.debugString, 32'd0);
      reset_n = 1'b1;
      step(6);

      // Grant latency: 3 edges from the request edge.
      sb_q.push_back(mk(5'd1, 1'b0, 1'b0));
      bus.buttonRequest[0] = 1'b1;
      step(2);
      chk("lat_early", {27'd0, bus.currentState}, 32'd0);
      step(1);
      chk("lat_grant", {27'd0, bus.currentState}, 32'd1);
      chk("dbg_state", {27'd0, bus.debugString[31:27]}, 32'd1);

      // Completion exits within 3 cycles; button 0 stays high throughout.
      step(5);
      sb_q.push_back(mk(5'd0, 1'b0, 1'b0));
      bus.stateCompleteVec[1] = 1'b1;
      step(3);
      chk("done_exit", {27'd0, bus.currentState}, 32'd0);
      bus.stateCompleteVec[1] = 1'b0;
      chk("holdoff_set", {31'd0, bus.debugString[25]}, 32'd1);
      pulse_btn(4'b0011);
      bus.buttonRequest[0] = 1'b1;
      step(10);
      chk("holdoff_ignore", {27'd0, bus.currentState}, 32'd0);
      wait_holdoff("holdoff1");
      step(40);
      chk("level_no_regrant", {27'd0, bus.currentState}, 32'd0);
      bus.buttonRequest[0] = 1'b0;
      step(4);

      // Song2 after holdoff, then cancel.
      sb_q.push_back(mk(5'd2, 1'b0, 1'b0));
      pulse_btn(4'b0010);
      wait_state(5'd2, 10, "grant_song2");
      sb_q.push_back(mk(5'd0, 1'b0, 1'b0));
      bus.cancelRequest = 1'b1;
      wait_state(5'd0, 10, "cancel_exit");
      bus.cancelRequest = 1'b0;
      wait_holdoff("holdoff2");

      // Simultaneous edges: lowest index wins.
      sb_q.push_back(mk(5'd2, 1'b0, 1'b0));
      pulse_btn(4'b0110);
      wait_state(5'd2, 10, "simul_grant");
      sb_q.push_back(mk(5'd0, 1'b0, 1'b0));
      bus.stateCompleteVec[2] = 1'b1;
      wait_state(5'd0, 10, "song2_done");
      bus.stateCompleteVec[2] = 1'b0;
      wait_holdoff("holdoff3");

      // Playback without a valid recording is ignored.
      pulse_btn(4'b1000);
      step(10);
      chk("playback_blocked", {27'd0, bus.currentState}, 32'd0);

      // Cancel and completion together in RecordSong count as cancel.
      sb_q.push_back(mk(5'd3, 1'b0, 1'b0));
      pulse_btn(4'b0100);
      wait_state(5'd3, 10, "grant_record_a");
      sb_q.push_back(mk(5'd0, 1'b0, 1'b0));
      bus.cancelRequest = 1'b1;
      bus.stateCompleteVec[3] = 1'b1;
      wait_state(5'd0, 10, "cancel_done_exit");
      chk("cancel_wins_rv", {31'd0, bus.recordingValid}, 32'd0);
      bus.cancelRequest = 1'b0;
      bus.stateCompleteVec[3] = 1'b0;
      wait_holdoff("holdoff4");

      // Recording completes normally.
      sb_q.push_back(mk(5'd3, 1'b0, 1'b0));
      pulse_btn(4'b0100);
      wait_state(5'd3, 10, "grant_record_b");
      sb_q.push_back(mk(5'd0, 1'b1, 1'b0));
      bus.stateCompleteVec[3] = 1'b1;
      wait_state(5'd0, 10, "record_done");
      chk("rec_valid_set", {31'd0, bus.recordingValid}, 32'd1);
      bus.stateCompleteVec[3] = 1'b0;
      wait_holdoff("holdoff5");

      // Playback now allowed.
      sb_q.push_back(mk(5'd4, 1'b1, 1'b0));
      pulse_btn(4'b1000);
      wait_state(5'd4, 10, "grant_playback");
      sb_q.push_back(mk(5'd0, 1'b1, 1'b0));
      bus.stateCompleteVec[4] = 1'b1;
      wait_state(5'd0, 10, "playback_done");
      bus.stateCompleteVec[4] = 1'b0;
      wait_holdoff("holdoff6");

      // Watchdog: 10th tick after entry forces exit with a 1-cycle flag.
      to_cycles = 0;
      sb_q.push_back(mk(5'd1, 1'b1, 1'b0));
      bus.buttonRequest[0] = 1'b1;
      wait_state(5'd1, 10, "grant_timeout");
      t0 = cyc;
      bus.buttonRequest[0] = 1'b0;
      sb_q.push_back(mk(5'd0, 1'b1, 1'b1));
      wait_state(5'd0, 200, "timeout_exit");
      elapsed = cyc - t0;
      chk("timeout_window", {31'd0, (elapsed >= 73 && elapsed <= 80)}, 32'd1);
      step(3);
      chk("timeout_width", to_cycles, 32'd1);
      wait_holdoff("holdoff7");

      // Asynchronous reset mid-mode.
      sb_q.push_back(mk(5'd1, 1'b1, 1'b0));
      bus.buttonRequest[0] = 1'b1;
      wait_state(5'd1, 10, "grant_prereset");
      bus.buttonRequest[0] = 1'b0;
      sb_q.push_back(mk(5'd0, 1'b0, 1'b0));
      step(5);
      #4 reset_n = 1'b0;
      #1;
      chk("areset_state", {27'd0, bus.currentState}, 32'd0);
      chk("areset_recvalid", {31'd0, bus.recordingValid}, 32'd0);
      chk("areset_debug", bus.debugString, 32'd0);
      step(2);
      reset_n = 1'b1;
      step(5);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
